// File: rtl/serv_decode_pkg.sv
// Shared opcode constants and the pre-decoded FIFO entry layout for serv_decode_fifo.
package serv_decode_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned CSRB_W = 4;
    localparam int unsigned REG_W  = 5;

    // instr[6:2] major opcodes
    localparam logic [OPC_W-1:0] OPC_LOAD     = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_STORE    = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_OP       = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_LUI      = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_JALR     = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JAL      = 5'b11011;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [F3_W-1:0]   funct3;
        logic              imm30;
        logic [CSRB_W-1:0] csr_bits;
        logic [REG_W-1:0]  rd_addr;
        logic [REG_W-1:0]  rs1_addr;
        logic [REG_W-1:0]  rs2_addr;
        logic              mem_op;
        logic              branch_op;
        logic              shift_op;
        logic              slt_op;
        logic              csr_op;
        logic              e_op;
        logic              mret;
        logic              rd_op;
        logic              illegal;
        logic              mdu_op;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: opc_legal = 1'b1;
            default:                                                   opc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serv_predecode.sv
// Combinational instruction word -> pre-decoded FIFO entry.
// SERV_DECODE_MDU_EN enables decoding of M-extension OP words.
module serv_predecode
    import serv_decode_pkg::*;
#(
    parameter int unsigned RV32E = 0
) (
    input  logic [31:0] i_instr,
    output entry_t      o_entry
);

    logic [OPC_W-1:0] w_opc;
    logic [F3_W-1:0]  w_f3;
    logic [6:0]       w_f7;
    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic w_is_op, w_is_opimm, w_is_sys, w_alu, w_mul, w_mdu, w_mul_ill;
    logic w_writes_rd, w_rs1_used, w_rs2_used, w_e_bad;

    assign w_opc = i_instr[6:2];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign w_rd  = i_instr[11:7];
    assign w_rs1 = i_instr[19:15];
    assign w_rs2 = i_instr[24:20];

    assign w_is_op    = (w_opc == OPC_OP);
    assign w_is_opimm = (w_opc == OPC_OP_IMM);
    assign w_is_sys   = (w_opc == OPC_SYSTEM);
    assign w_alu      = w_is_op | w_is_opimm;
    assign w_mul      = w_is_op & (w_f7 == 7'b0000001);

`ifdef SERV_DECODE_MDU_EN
    assign w_mdu     = w_mul;
    assign w_mul_ill = 1'b0;
`else
    assign w_mdu     = 1'b0;
    assign w_mul_ill = w_mul;
`endif

    assign w_writes_rd = (w_opc == OPC_LOAD) | w_is_opimm | (w_opc == OPC_AUIPC) | w_is_op |
                         (w_opc == OPC_LUI) | (w_opc == OPC_JALR) | (w_opc == OPC_JAL) |
                         (w_is_sys & (w_f3 != 3'b000));
    // CSR immediate forms (funct3[2]=1) carry a zimm, not a register, in the rs1 field
    assign w_rs1_used  = (w_opc == OPC_LOAD) | (w_opc == OPC_STORE) | (w_opc == OPC_BRANCH) |
                         (w_opc == OPC_JALR) | w_alu | (w_is_sys & (w_f3 != 3'b000) & !w_f3[2]);
    assign w_rs2_used  = (w_opc == OPC_STORE) | (w_opc == OPC_BRANCH) | w_is_op;
    assign w_e_bad     = (RV32E != 0) & ((w_writes_rd & w_rd[4]) | (w_rs1_used & w_rs1[4]) |
                                         (w_rs2_used & w_rs2[4]));

    always_comb begin
        o_entry           = '0;
        o_entry.opcode    = w_opc;
        o_entry.funct3    = w_f3;
        o_entry.imm30     = i_instr[30];
        o_entry.csr_bits  = {i_instr[26], i_instr[22], i_instr[21], i_instr[20]};
        o_entry.rd_addr   = w_rd;
        o_entry.rs1_addr  = w_rs1;
        o_entry.rs2_addr  = w_rs2;
        o_entry.mem_op    = !w_opc[4] & !w_opc[2] & !w_opc[0];
        o_entry.branch_op = w_opc[4] & !w_opc[2];
        o_entry.shift_op  = w_alu & (w_f3[1:0] == 2'b01) & !w_mdu;
        o_entry.slt_op    = w_alu & (w_f3[2:1] == 2'b01) & !w_mdu;
        o_entry.csr_op    = w_is_sys & (w_f3 != 3'b000);
        o_entry.e_op      = w_is_sys & (w_f3 == 3'b000) & !i_instr[21];
        o_entry.mret      = w_is_sys & (w_f3 == 3'b000) & i_instr[21];
        o_entry.rd_op     = w_writes_rd & (w_rd != 5'd0);
        o_entry.illegal   = (i_instr[1:0] != 2'b11) | !opc_legal(w_opc) | w_mul_ill | w_e_bad;
        o_entry.mdu_op    = w_mdu;
    end

endmodule

// File: rtl/serv_decode_fifo.sv
// Circular FIFO of pre-decoded instruction entries with valid/pop handshake at the head.
// SERV_DECODE_MDU_EN enables M-extension decoding (o_mdu_op).
module serv_decode_fifo
    import serv_decode_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned RV32E = 0,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_en,
    output logic             o_push_ready,
    input  logic             i_flush,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow,
    output logic [4:0]       o_opcode,
    output logic [2:0]       o_funct3,
    output logic             o_imm30,
    output logic [3:0]       o_csr_bits,
    output logic [4:0]       o_rd_addr,
    output logic [4:0]       o_rs1_addr,
    output logic [4:0]       o_rs2_addr,
    output logic             o_mem_op,
    output logic             o_branch_op,
    output logic             o_shift_op,
    output logic             o_slt_op,
    output logic             o_csr_op,
    output logic             o_e_op,
    output logic             o_mret,
    output logic             o_rd_op,
    output logic             o_illegal,
    output logic             o_mdu_op
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           w_new_entry;
    entry_t           w_head;
    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_valid, r_overflow;
    logic             w_push_ready, w_push, w_pop;

    serv_predecode #(.RV32E(RV32E)) u_predecode (
        .i_instr (i_wb_rdt),
        .o_entry (w_new_entry)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push_ready = (r_count < CNT_W'(DEPTH)) | (i_pop & r_valid);
    assign w_push       = i_wb_en & w_push_ready & !i_flush;
    assign w_pop        = i_pop & r_valid & !i_flush;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Control state; flush outranks push and pop, reset outranks everything
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (i_wb_en & !w_push_ready) r_overflow <= 1'b1;
        end
    end

    // Entry storage is not reset; r_valid qualifies it
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_new_entry;
    end

    assign w_head = r_mem[r_rd_ptr];

    assign o_push_ready = w_push_ready;
    assign o_valid      = r_valid;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;
    assign o_opcode     = w_head.opcode;
    assign o_funct3     = w_head.funct3;
    assign o_imm30      = w_head.imm30;
    assign o_csr_bits   = w_head.csr_bits;
    assign o_rd_addr    = w_head.rd_addr;
    assign o_rs1_addr   = w_head.rs1_addr;
    assign o_rs2_addr   = w_head.rs2_addr;
    assign o_mem_op     = w_head.mem_op    & r_valid;
    assign o_branch_op  = w_head.branch_op & r_valid;
    assign o_shift_op   = w_head.shift_op  & r_valid;
    assign o_slt_op     = w_head.slt_op    & r_valid;
    assign o_csr_op     = w_head.csr_op    & r_valid;
    assign o_e_op       = w_head.e_op      & r_valid;
    assign o_mret       = w_head.mret      & r_valid;
    assign o_rd_op      = w_head.rd_op     & r_valid;
    assign o_illegal    = w_head.illegal   & r_valid;
    assign o_mdu_op     = w_head.mdu_op    & r_valid;

endmodule

// File: tb/tb_serv_decode_fifo.sv
// Scoreboard bench for serv_decode_fifo: DEPTH=2 instance plus an RV32E instance on the same stimulus.
module tb_serv_decode_fifo;

    logic        clk = 1'b0;
    logic        i_rst, i_wb_en, i_flush, i_pop;
    logic [31:0] i_wb_rdt;

    logic       o_push_ready, o_valid, o_overflow, o_imm30;
    logic [1:0] o_count;
    logic [4:0] o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr;
    logic [2:0] o_funct3;
    logic [3:0] o_csr_bits;
    logic o_mem_op, o_branch_op, o_shift_op, o_slt_op, o_csr_op, o_e_op, o_mret, o_rd_op, o_illegal, o_mdu_op;

    logic       e_push_ready, e_valid, e_overflow, e_imm30;
    logic [1:0] e_count;
    logic [4:0] e_opcode, e_rd_addr, e_rs1_addr, e_rs2_addr;
    logic [2:0] e_funct3;
    logic [3:0] e_csr_bits;
    logic e_mem_op, e_branch_op, e_shift_op, e_slt_op, e_csr_op, e_e_op, e_mret, e_rd_op, e_illegal, e_mdu_op;

    logic [9:0] w_flags;
    assign w_flags = {o_mem_op, o_branch_op, o_shift_op, o_slt_op, o_csr_op,
                      o_e_op, o_mret, o_rd_op, o_illegal, o_mdu_op};

    typedef struct packed {
        logic [31:0] w;
        logic [4:0]  opc;
        logic [4:0]  rd;
        logic [9:0]  fl;
        logic        ill_e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t vec[9];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serv_decode_fifo #(.DEPTH(2), .RV32E(0)) dut (
        .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
        .o_push_ready(o_push_ready), .i_flush(i_flush), .i_pop(i_pop),
        .o_valid(o_valid), .o_count(o_count), .o_overflow(o_overflow),
        .o_opcode(o_opcode), .o_funct3(o_funct3), .o_imm30(o_imm30), .o_csr_bits(o_csr_bits),
        .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .o_mem_op(o_mem_op), .o_branch_op(o_branch_op), .o_shift_op(o_shift_op),
        .o_slt_op(o_slt_op), .o_csr_op(o_csr_op), .o_e_op(o_e_op), .o_mret(o_mret),
        .o_rd_op(o_rd_op), .o_illegal(o_illegal), .o_mdu_op(o_mdu_op)
    );

    serv_decode_fifo #(.DEPTH(2), .RV32E(1)) dut_e (
        .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
        .o_push_ready(e_push_ready), .i_flush(i_flush), .i_pop(i_pop),
        .o_valid(e_valid), .o_count(e_count), .o_overflow(e_overflow),
        .o_opcode(e_opcode), .o_funct3(e_funct3), .o_imm30(e_imm30), .o_csr_bits(e_csr_bits),
        .o_rd_addr(e_rd_addr), .o_rs1_addr(e_rs1_addr), .o_rs2_addr(e_rs2_addr),
        .o_mem_op(e_mem_op), .o_branch_op(e_branch_op), .o_shift_op(e_shift_op),
        .o_slt_op(e_slt_op), .o_csr_op(e_csr_op), .o_e_op(e_e_op), .o_mret(e_mret),
        .o_rd_op(e_rd_op), .o_illegal(e_illegal), .o_mdu_op(e_mdu_op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] w, input logic [4:0] opc, input logic [4:0] rd,
                                input logic [9:0] fl, input logic ill_e);
        exp_t e;
        e.w = w; e.opc = opc; e.rd = rd; e.fl = fl; e.ill_e = ill_e;
        return e;
    endfunction

    task automatic drive(input logic en, input logic [31:0] w, input logic pop, input logic fl);
        i_wb_en = en; i_wb_rdt = w; i_pop = pop; i_flush = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every effective pop retires the head against the scoreboard
    always @(negedge clk) begin
        if (!i_rst && !i_flush && i_pop && o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'(o_opcode), 32'hffff_ffff);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("opcode[%h]", mon_e.w), 32'(o_opcode), 32'(mon_e.opc));
                chk($sformatf("rd[%h]", mon_e.w), 32'(o_rd_addr), 32'(mon_e.rd));
                chk($sformatf("flags[%h]", mon_e.w), 32'(w_flags), 32'(mon_e.fl));
                chk($sformatf("rv32e_illegal[%h]", mon_e.w), 32'(e_illegal), 32'(mon_e.ill_e));
            end
        end
    end

    initial begin
        // flags order: mem branch shift slt csr e mret rd_op illegal mdu
        vec[0] = mk(32'h01000893, 5'b00100, 5'd17, 10'b0000000100, 1'b1);
        vec[1] = mk(32'h00000000, 5'b00000, 5'd0,  10'b1000000010, 1'b1);
`ifdef SERV_DECODE_MDU_EN
        vec[2] = mk(32'h022081b3, 5'b01100, 5'd3,  10'b0000000101, 1'b0);
`else
        vec[2] = mk(32'h022081b3, 5'b01100, 5'd3,  10'b0000000110, 1'b1);
`endif
        vec[3] = mk(32'h00209193, 5'b00100, 5'd3,  10'b0010000100, 1'b0);
        vec[4] = mk(32'h007322B3, 5'b01100, 5'd5,  10'b0001000100, 1'b0);
        vec[5] = mk(32'h00208063, 5'b11000, 5'd0,  10'b0100000000, 1'b0);
        vec[6] = mk(32'h0000A203, 5'b00000, 5'd4,  10'b1000000100, 1'b0);
        vec[7] = mk(32'h340110F3, 5'b11100, 5'd1,  10'b0000100100, 1'b0);
        vec[8] = mk(32'h00000073, 5'b11100, 5'd0,  10'b0000010000, 1'b0);

        i_rst = 1'b1; i_wb_en = 1'b0; i_wb_rdt = '0; i_flush = 1'b0; i_pop = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_overflow", 32'(o_overflow), 0);
        chk("rst_ready", 32'(o_push_ready), 1);
        chk("rst_flags", 32'(w_flags), 0);

        // Single push: visible at the head one cycle later
        exp_q.push_back(mk(32'h00500093, 5'b00100, 5'd1, 10'b0000000100, 1'b0));
        drive(1'b1, 32'h00500093, 1'b0, 1'b0);
        chk("t1_valid", 32'(o_valid), 1);
        chk("t1_count", 32'(o_count), 1);
        chk("t1_opcode", 32'(o_opcode), 32'(5'b00100));
        chk("t1_rd", 32'(o_rd_addr), 1);
        chk("t1_rd_op", 32'(o_rd_op), 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("t1_count_after_pop", 32'(o_count), 0);
        chk("t1_valid_after_pop", 32'(o_valid), 0);

        // Three pushes into DEPTH=2: third dropped, overflow sticks
        exp_q.push_back(mk(32'h00000013, 5'b00100, 5'd0, 10'b0000000000, 1'b0));
        drive(1'b1, 32'h00000013, 1'b0, 1'b0);
        exp_q.push_back(mk(32'h30200073, 5'b11100, 5'd0, 10'b0000001000, 1'b0));
        drive(1'b1, 32'h30200073, 1'b0, 1'b0);
        i_wb_en = 1'b1; i_wb_rdt = 32'h00100113; #1;
        chk("full_ready", 32'(o_push_ready), 0);
        drive(1'b1, 32'h00100113, 1'b0, 1'b0);
        chk("full_count", 32'(o_count), 2);
        chk("full_overflow", 32'(o_overflow), 1);

        // Full with push+pop: ready, count unchanged, new word queued behind remaining entry
        i_wb_en = 1'b1; i_wb_rdt = 32'h00000073; i_pop = 1'b1; #1;
        chk("pushpop_ready", 32'(o_push_ready), 1);
        exp_q.push_back(mk(32'h00000073, 5'b11100, 5'd0, 10'b0000010000, 1'b0));
        drive(1'b1, 32'h00000073, 1'b1, 1'b0);
        chk("pushpop_count", 32'(o_count), 2);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("drain_count", 32'(o_count), 0);
        chk("overflow_sticky", 32'(o_overflow), 1);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("empty_pop_count", 32'(o_count), 0);

        // Flush with push and pop pending
        exp_q.push_back(mk(32'h00500093, 5'b00100, 5'd1, 10'b0000000100, 1'b0));
        drive(1'b1, 32'h00500093, 1'b0, 1'b0);
        exp_q.push_back(mk(32'h00000013, 5'b00100, 5'd0, 10'b0000000000, 1'b0));
        drive(1'b1, 32'h00000013, 1'b0, 1'b0);
        chk("preflush_count", 32'(o_count), 2);
        drive(1'b1, 32'h00100113, 1'b1, 1'b1);
        exp_q.delete();
        i_flush = 1'b0;
        chk("flush_count", 32'(o_count), 0);
        chk("flush_valid", 32'(o_valid), 0);
        chk("flush_overflow", 32'(o_overflow), 0);
        chk("flush_flags", 32'(w_flags), 0);

        // Reset while pushing and popping
        drive(1'b1, 32'h00500093, 1'b0, 1'b0);
        i_rst = 1'b1;
        drive(1'b1, 32'h00000013, 1'b1, 1'b0);
        i_rst = 1'b0;
        chk("midrst_count", 32'(o_count), 0);
        chk("midrst_valid", 32'(o_valid), 0);

        // Streaming push with continuous pop
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(vec[i]);
            drive(1'b1, vec[i].w, 1'b1, 1'b0);
        end
        i_wb_en = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(1'b0, '0, 1'b1, 1'b0);
        chk("stream_drained", 32'(exp_q.size()), 0);
        chk("stream_count", 32'(o_count), 0);
        i_pop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
